// File: rtl/alu_arbiter_if.sv
// Request/response bundle between NUM_REQ Alu clients and the shared arbiter.
// Request fields are packed per requester; the response side is a single slot.
interface alu_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
);
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ-1:0]    req_lock;
  logic [NUM_REQ*4-1:0]  req_ctrl;
  logic [NUM_REQ*32-1:0] req_op1;
  logic [NUM_REQ*32-1:0] req_op2;

  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [ID_W-1:0]       rsp_id;
  logic [31:0]           rsp_result;
  logic                  rsp_zero;
  logic [31:0]           grant_count;

  modport master (
    output req_valid, req_lock, req_ctrl, req_op1, req_op2, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_result, rsp_zero, grant_count
  );

  modport slave (
    input  req_valid, req_lock, req_ctrl, req_op1, req_op2, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_result, rsp_zero, grant_count
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter with burst lock sharing one Alu among NUM_REQ requesters.
// One-cycle latency into a single response slot; no grant while the slot is full and not draining.
module alu_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic         clock,
  input  logic         reset_n,
  alu_arbiter_if.slave bus
);

  localparam logic [0:0] ST_UNLOCKED = 1'b0;
  localparam logic [0:0] ST_LOCKED   = 1'b1;

  localparam logic [3:0] OP_SLL = 4'd0;
  localparam logic [3:0] OP_SRL = 4'd1;
  localparam logic [3:0] OP_SRA = 4'd2;
  localparam logic [3:0] OP_ADD = 4'd3;
  localparam logic [3:0] OP_SUB = 4'd4;
  localparam logic [3:0] OP_AND = 4'd5;
  localparam logic [3:0] OP_OR  = 4'd6;
  localparam logic [3:0] OP_XOR = 4'd7;
  localparam logic [3:0] OP_NOR = 4'd8;
  localparam logic [3:0] OP_SLT = 4'd9;
  localparam logic [3:0] OP_LUI = 4'd10;

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [31:0]     result;
    logic            zero;
  } rsp_t;

  logic [0:0]      state;
  logic [ID_W-1:0] ptr;
  logic [ID_W-1:0] owner;
  logic            slot_vld;
  rsp_t            slot;
  logic [31:0]     grant_cnt;

  logic            free;
  logic            win_vld;
  logic [ID_W-1:0] winner;
  logic            accept;
  logic [ID_W:0]   scan_idx;
  logic [ID_W-1:0] scan_sel;
  logic [31:0]     alu_res;
  rsp_t            alu_rsp;

  logic [3:0]  ctrl_a [NUM_REQ];
  logic [31:0] op1_a  [NUM_REQ];
  logic [31:0] op2_a  [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign ctrl_a[g] = bus.req_ctrl[4*g +: 4];
    assign op1_a[g]  = bus.req_op1[32*g +: 32];
    assign op2_a[g]  = bus.req_op2[32*g +: 32];
  end

  function automatic logic [31:0] alu_eval(input logic [3:0] ctrl,
                                           input logic [31:0] a,
                                           input logic [31:0] b);
    logic [31:0] r;
    r = '0;
    case (ctrl)
      OP_SLL:  r = a << b[4:0];
      OP_SRL:  r = a >> b[4:0];
      OP_SRA:  r = $unsigned($signed(a) >>> b[4:0]);
      OP_ADD:  r = a + b;
      OP_SUB:  r = a - b;
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_NOR:  r = ~(a | b);
      OP_SLT:  r = {31'd0, (a < b)};
      OP_LUI:  r = a << 16;
      default: r = '0;
    endcase
    return r;
  endfunction

  function automatic logic [ID_W-1:0] next_idx(input logic [ID_W-1:0] i);
    logic [ID_W-1:0] n;
    if (i == ID_W'(NUM_REQ - 1)) n = '0;
    else                         n = i + 1'b1;
    return n;
  endfunction

  // A full slot may still accept when the consumer drains it this same edge.
  assign free = !slot_vld || bus.rsp_ready;

  always_comb begin
    win_vld  = 1'b0;
    winner   = '0;
    scan_idx = '0;
    scan_sel = '0;
    if (state == ST_LOCKED) begin
      // Owner keeps exclusive eligibility; everyone else stalls even if it idles.
      win_vld = bus.req_valid[owner];
      winner  = owner;
    end else begin
      for (int k = 0; k < NUM_REQ; k++) begin
        scan_idx = {1'b0, ptr} + (ID_W+1)'(k);
        if (scan_idx >= (ID_W+1)'(NUM_REQ)) scan_idx = scan_idx - (ID_W+1)'(NUM_REQ);
        scan_sel = scan_idx[ID_W-1:0];
        if (!win_vld && bus.req_valid[scan_sel]) begin
          win_vld = 1'b1;
          winner  = scan_sel;
        end
      end
    end
  end

  assign accept        = reset_n && free && win_vld;
  assign bus.req_ready = accept ? (NUM_REQ'(1) << winner) : '0;

  assign alu_res        = alu_eval(ctrl_a[winner], op1_a[winner], op2_a[winner]);
  assign alu_rsp.id     = winner;
  assign alu_rsp.result = alu_res;
  assign alu_rsp.zero   = (alu_res == 32'd0);

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state     <= ST_UNLOCKED;
      ptr       <= '0;
      owner     <= '0;
      slot_vld  <= 1'b0;
      slot      <= '0;
      grant_cnt <= '0;
    end else begin
      if (accept) begin
        slot_vld  <= 1'b1;
        slot      <= alu_rsp;
        grant_cnt <= grant_cnt + 32'd1;
        case (state)
          ST_UNLOCKED: begin
            ptr <= next_idx(winner);
            if (bus.req_lock[winner]) begin
              state <= ST_LOCKED;
              owner <= winner;
            end
          end
          default: begin
            // Pointer was frozen for the whole burst; resume after the owner.
            if (!bus.req_lock[owner]) begin
              state <= ST_UNLOCKED;
              ptr   <= next_idx(owner);
            end
          end
        endcase
      end else if (bus.rsp_ready) begin
        slot_vld <= 1'b0;
      end
    end
  end

  assign bus.rsp_valid   = slot_vld;
  assign bus.rsp_id      = slot.id;
  assign bus.rsp_result  = slot.result;
  assign bus.rsp_zero    = slot.zero;
  assign bus.grant_count = grant_cnt;

  a_ready_onehot: assert property (@(posedge clock) disable iff (!reset_n)
    $onehot0(bus.req_ready));

  a_no_grant_when_full: assert property (@(posedge clock) disable iff (!reset_n)
    (slot_vld && !bus.rsp_ready) |-> (bus.req_ready == '0));

endmodule
